// File: rtl/sweep_cmd_sequencer_if.sv
// rtl/sweep_cmd_sequencer_if.sv - command-push and writer-control bundle for the sweep sequencer
interface sweep_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_dir;
  logic       cmd_ready;
  logic       go;
  logic       direction;
  logic       done;
  logic [4:0] regnum;

  modport master (
    input  cmd_valid, cmd_dir, done, regnum,
    output cmd_ready, go, direction
  );

  modport slave (
    output cmd_valid, cmd_dir, done, regnum,
    input  cmd_ready, go, direction
  );
endinterface

// File: rtl/sweep_cmd_sequencer.sv
// rtl/sweep_cmd_sequencer.sv - queued sweep-command issuer and writer-sequence checker
module sweep_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  sweep_cmd_sequencer_if.master bus,
  output logic                  busy,
  output logic [CNT_W-1:0]      sweep_count,
  output logic                  error,
  output logic [4:0]            err_expected,
  output logic [4:0]            err_actual
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GO,
    S_WAIT_START,
    S_RUN,
    S_CHECK
  } state_t;

  state_t                r_state;
  logic [FIFO_DEPTH-1:0] r_fifo;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [OCC_W-1:0]      r_occ;
  logic                  r_dir;
  logic                  r_go;
  logic                  r_bad;
  logic                  r_error;
  logic [1:0]            r_step;
  logic [CNT_W-1:0]      r_count;
  logic [4:0]            r_err_exp;
  logic [4:0]            r_err_act;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_head;
  logic                  w_check_en;
  logic                  w_exp_done;
  logic [4:0]            w_exp_reg;
  logic                  w_done_mis;
  logic                  w_reg_mis;
  logic                  w_mis;
  logic [4:0]            w_cap_exp;
  logic [4:0]            w_cap_act;

  assign w_full  = (r_occ == OCC_W'(FIFO_DEPTH));
  assign w_empty = (r_occ == '0);
  assign w_push  = bus.cmd_valid & ~w_full;
  assign w_pop   = ~w_empty & ((r_state == S_IDLE) | (r_state == S_CHECK));
  assign w_head  = r_fifo[r_rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fifo   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= bus.cmd_dir;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Expected writer outputs for the current cycle of the fixed 7-cycle sweep
  always_comb begin
    w_check_en = 1'b0;
    w_exp_done = 1'b0;
    w_exp_reg  = 5'd0;
    case (r_state)
      S_WAIT_START: begin
        w_check_en = 1'b1;
        w_exp_reg  = 5'd8;
      end
      S_RUN: begin
        w_check_en = 1'b1;
        w_exp_reg  = r_dir ? (5'd9 + {3'b000, r_step}) : (5'd7 - {3'b000, r_step});
      end
      S_CHECK: begin
        w_check_en = 1'b1;
        w_exp_done = 1'b1;
      end
      default: begin
        w_check_en = 1'b0;
      end
    endcase
  end

  assign w_done_mis = w_check_en & (bus.done != w_exp_done);
  assign w_reg_mis  = w_check_en & (bus.regnum != w_exp_reg);
  assign w_mis      = w_done_mis | w_reg_mis;
  // A done mismatch takes precedence and is reported with the 31 marker
  assign w_cap_exp  = w_done_mis ? 5'd31 : w_exp_reg;
  assign w_cap_act  = w_done_mis ? {4'b0000, bus.done} : bus.regnum;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_dir     <= 1'b0;
      r_go      <= 1'b0;
      r_bad     <= 1'b0;
      r_step    <= 2'd0;
      r_count   <= '0;
      r_error   <= 1'b0;
      r_err_exp <= 5'd0;
      r_err_act <= 5'd0;
    end else begin
      r_go <= 1'b0;
      if (w_mis) begin
        r_bad <= 1'b1;
        if (!r_error) begin
          r_error   <= 1'b1;
          r_err_exp <= w_cap_exp;
          r_err_act <= w_cap_act;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_dir   <= w_head;
            r_go    <= 1'b1;
            r_state <= S_GO;
          end
        end
        S_GO: begin
          r_bad   <= 1'b0;
          r_state <= S_WAIT_START;
        end
        S_WAIT_START: begin
          r_step  <= 2'd0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (r_step == 2'd3) begin
            r_state <= S_CHECK;
          end else begin
            r_step <= r_step + 2'd1;
          end
        end
        S_CHECK: begin
          if (!(r_bad | w_mis)) begin
            r_count <= r_count + CNT_W'(1);
          end
          if (w_pop) begin
            r_dir   <= w_head;
            r_go    <= 1'b1;
            r_state <= S_GO;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = ~w_full;
  assign bus.go        = r_go;
  assign bus.direction = r_dir;
  assign busy          = (r_state != S_IDLE) | ~w_empty;
  assign sweep_count   = r_count;
  assign error         = r_error;
  assign err_expected  = r_err_exp;
  assign err_actual    = r_err_act;
endmodule

// File: tb/tb_sweep_cmd_sequencer.sv
// tb/tb_sweep_cmd_sequencer.sv - randomized bench with scheduling reference model and writer model
module tb_sweep_cmd_sequencer;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] sweep_count;
  logic             error;
  logic [4:0]       err_expected;
  logic [4:0]       err_actual;

  sweep_cmd_sequencer_if bus();

  sweep_cmd_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .busy         (busy),
    .sweep_count  (sweep_count),
    .error        (error),
    .err_expected (err_expected),
    .err_actual   (err_actual)
  );

  always #5 clock = ~clock;

  // kind: 0 clean, 1 wrong regnum at pos (0 = start, 1..4 = run steps), 2 missing done
  typedef struct {
    bit       dir;
    int       kind;
    int       pos;
    bit [4:0] fval;
  } rec_t;

  int   t = 0;
  int   checks = 0;
  int   failures = 0;

  rec_t mq[$];
  rec_t wq[$];
  bit   go_at[int];
  bit   gdir_at[int];
  int   inc_at[int];
  int   err_cycle = -1;
  int   err_e = 0;
  int   err_a = 0;
  int   model_count = 0;
  int   next_pop_ok = 0;
  int   last_p = -100;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, t, got, exp);
    end
  endtask

  function automatic int exp_reg(input bit dir, input int pos);
    if (pos == 0) return 8;
    if (pos >= 5) return 0;
    return dir ? (9 + pos - 1) : (7 - (pos - 1));
  endfunction

  function automatic rec_t mk(input bit dir, input int kind, input int pos, input int fval);
    rec_t r;
    r.dir  = dir;
    r.kind = kind;
    r.pos  = pos;
    r.fval = fval[4:0];
    return r;
  endfunction

  // Writer model: 8 after go, then the four sweep values, then done with regnum 0
  initial begin
    int   wp;
    bit   g;
    bit   gd;
    bit   cdir;
    rec_t cur;
    wp = 0;
    cdir = 1'b0;
    cur = mk(1'b0, 0, 0, 0);
    bus.done = 1'b0;
    bus.regnum = 5'd0;
    forever begin
      @(negedge clock);
      g  = bus.go;
      gd = bus.direction;
      @(posedge clock);
      #1;
      if (!reset) begin
        wp = 0;
      end else if (g) begin
        cur  = (wq.size() != 0) ? wq.pop_front() : mk(1'b0, 0, 0, 0);
        cdir = gd;
        wp   = 1;
      end else if (wp != 0 && wp < 6) begin
        wp++;
      end else begin
        wp = 0;
      end
      bus.done   = (wp == 6);
      bus.regnum = (wp == 0) ? 5'd0 : 5'(exp_reg(cdir, wp - 1));
      if (wp != 0 && cur.kind == 1 && cur.pos == wp - 1) bus.regnum = cur.fval;
      if (wp == 6 && cur.kind == 2) bus.done = 1'b0;
    end
  end

  task automatic step(input bit v, input rec_t r);
    bit   rdy_e;
    bit   busy_e;
    bit   err_on;
    rec_t pr;
    bus.cmd_valid = v;
    bus.cmd_dir   = r.dir;
    @(negedge clock);
    rdy_e  = (mq.size() < FIFO_DEPTH);
    busy_e = (mq.size() != 0) || (t >= last_p + 1 && t <= last_p + 7);
    if (inc_at.exists(t)) model_count += inc_at[t];
    err_on = (err_cycle >= 0) && (t >= err_cycle);
    check_val("cmd_ready", bus.cmd_ready, rdy_e);
    check_val("go", bus.go, go_at.exists(t));
    if (go_at.exists(t)) check_val("direction", bus.direction, gdir_at[t]);
    check_val("busy", busy, busy_e);
    check_val("sweep_count", sweep_count, model_count % (1 << CNT_W));
    check_val("error", error, err_on);
    check_val("err_expected", err_expected, err_on ? err_e : 0);
    check_val("err_actual", err_actual, err_on ? err_a : 0);
    if (mq.size() != 0 && t >= next_pop_ok) begin
      pr = mq.pop_front();
      wq.push_back(pr);
      go_at[t + 1]   = 1'b1;
      gdir_at[t + 1] = pr.dir;
      last_p         = t;
      next_pop_ok    = t + 7;
      if (pr.kind == 0) begin
        inc_at[t + 8] = 1;
      end else if (err_cycle < 0) begin
        err_cycle = t + 3 + pr.pos;
        err_e     = (pr.kind == 2) ? 31 : exp_reg(pr.dir, pr.pos);
        err_a     = (pr.kind == 2) ? 0 : int'(pr.fval);
      end
    end
    if (v && rdy_e) mq.push_back(r);
    @(posedge clock);
    #1;
    t++;
  endtask

  task automatic push(input bit dir, input int kind, input int pos, input int fval);
    step(1'b1, mk(dir, kind, pos, fval));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, mk(1'b0, 0, 0, 0));
  endtask

  task automatic model_clear();
    mq.delete();
    wq.delete();
    go_at.delete();
    gdir_at.delete();
    inc_at.delete();
    err_cycle   = -1;
    err_e       = 0;
    err_a       = 0;
    model_count = 0;
    next_pop_ok = 0;
    last_p      = -100;
  endtask

  task automatic do_reset();
    bus.cmd_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_val("rst_go", bus.go, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_error", error, 0);
    check_val("rst_count", sweep_count, 0);
    check_val("rst_ready", bus.cmd_ready, 1);
    check_val("rst_direction", bus.direction, 0);
    check_val("rst_err_expected", err_expected, 0);
    check_val("rst_err_actual", err_actual, 0);
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    model_clear();
    t += 2;
  endtask

  initial begin
    int pos;
    int kind;
    bit d;
    bus.cmd_valid = 1'b0;
    bus.cmd_dir   = 1'b0;
    @(posedge clock);
    #1;
    do_reset();

    // single up sweep, then back-to-back 1,0,1
    push(1'b1, 0, 0, 0);
    idle(10);
    push(1'b1, 0, 0, 0);
    push(1'b0, 0, 0, 0);
    push(1'b1, 0, 0, 0);
    idle(24);

    // six pushes back to back: fifth fills the queue, sixth is dropped
    for (int i = 0; i < 6; i++) push(i[0], 0, 0, 0);
    idle(42);

    // regnum 10 instead of 11, then a second fault that must not overwrite
    push(1'b1, 1, 3, 10);
    idle(10);
    push(1'b0, 1, 1, 0);
    push(1'b1, 0, 0, 0);
    idle(20);

    // missing done after a fresh reset
    do_reset();
    push(1'b0, 2, 5, 0);
    idle(10);

    // async reset mid-RUN with commands still queued
    push(1'b1, 0, 0, 0);
    push(1'b0, 0, 0, 0);
    push(1'b1, 0, 0, 0);
    idle(3);
    do_reset();
    idle(3);

    // five clean sweeps wrap a 2-bit counter to 1
    for (int i = 0; i < 5; i++) push(i[0], 0, 0, 0);
    idle(40);

    // randomized commands with occasional faults and periodic resets
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int i = 0; i < 120; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          d    = 1'($urandom_range(0, 1));
          kind = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
          pos  = (kind == 2) ? 5 : int'($urandom_range(0, 4));
          push(d, kind, pos, (kind == 1) ? (exp_reg(d, pos) ^ (1 << $urandom_range(0, 4))) : 0);
        end else begin
          idle(1);
        end
      end
      idle(40);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
